// File: rtl/pid_telemetry_tx.sv
// Captures PID samples on trig and streams them as a byte frame to a UART.
// Define TLM_CHECKSUM_EN to append a mod-256 payload checksum byte.
module pid_telemetry_tx #(
   parameter logic [7:0] HEADER      = 8'hAA,
   parameter int         ACK_TIMEOUT = 16
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        trig,
   input  logic [15:0] setpoint,
   input  logic [15:0] measure,
   input  logic [15:0] ctrl_out,
   input  logic        uart_busy,
   output logic        send,
   output logic [7:0]  send_data,
   output logic        tlm_busy,
   output logic        frame_done,
   output logic        err,
   output logic [7:0]  drop_cnt
);

`ifdef TLM_CHECKSUM_EN
   localparam int NBYTES = 8;
`else
   localparam int NBYTES = 7;
`endif
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [2:0]     r_idx, w_idx_nxt;
   logic [TW-1:0]  r_tmo, w_tmo_nxt;
   logic           r_send, w_send_nxt;
   logic [7:0]     r_sd, w_sd_nxt;
   logic           r_done, w_done_nxt;
   logic           r_err, w_err_nxt;
   logic [15:0]    r_sp, r_ms, r_co;
   logic [7:0]     r_drop;
   logic [7:0]     w_byte;
   logic           w_accept;
   logic           w_drop;
   logic           w_last;

   // The done/err cycle is already IDLE but still refuses a new trigger.
   assign w_accept = trig & (r_state == IDLE) & ~r_done & ~r_err;
   assign w_drop   = trig & ~w_accept;
   assign w_last   = (r_idx == 3'(NBYTES - 1));

`ifdef TLM_CHECKSUM_EN
   logic [7:0] w_csum;
   assign w_csum = r_sp[15:8] + r_sp[7:0] + r_ms[15:8]
                 + r_ms[7:0] + r_co[15:8] + r_co[7:0];
`endif

   always_comb begin
      w_byte = HEADER;
      case (r_idx)
         3'd0:    w_byte = HEADER;
         3'd1:    w_byte = r_sp[15:8];
         3'd2:    w_byte = r_sp[7:0];
         3'd3:    w_byte = r_ms[15:8];
         3'd4:    w_byte = r_ms[7:0];
         3'd5:    w_byte = r_co[15:8];
         3'd6:    w_byte = r_co[7:0];
`ifdef TLM_CHECKSUM_EN
         default: w_byte = w_csum;
`else
         default: w_byte = HEADER;
`endif
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_tmo_nxt   = r_tmo;
      w_send_nxt  = 1'b0;
      w_sd_nxt    = r_sd;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = ISSUE;
               w_idx_nxt   = 3'd0;
            end
         end
         ISSUE: begin
            if (!uart_busy) begin
               w_send_nxt  = 1'b1;
               w_sd_nxt    = w_byte;
               w_tmo_nxt   = '0;
               w_state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (uart_busy) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!uart_busy) begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 3'd1;
                  w_state_nxt = ISSUE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_tmo   <= '0;
         r_send  <= 1'b0;
         r_sd    <= 8'h00;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_sp    <= '0;
         r_ms    <= '0;
         r_co    <= '0;
         r_drop  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_tmo   <= w_tmo_nxt;
         r_send  <= w_send_nxt;
         r_sd    <= w_sd_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_sp <= setpoint;
            r_ms <= measure;
            r_co <= ctrl_out;
         end
         if (w_drop && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign send       = r_send;
   assign send_data  = r_sd;
   assign tlm_busy   = (r_state != IDLE);
   assign frame_done = r_done;
   assign err        = r_err;
   assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_pid_telemetry_tx.sv
// Scoreboard bench for pid_telemetry_tx: expected bytes queued at trigger,
// popped as the DUT strobes send. Follows TLM_CHECKSUM_EN like the RTL.
module tb_pid_telemetry_tx;

   localparam int ACKT = 16;
`ifdef TLM_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        trig;
   logic [15:0] setpoint, measure, ctrl_out;
   logic        uart_busy;
   logic        send;
   logic [7:0]  send_data;
   logic        tlm_busy;
   logic        frame_done;
   logic        err;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   pid_telemetry_tx #(.HEADER(8'hAA), .ACK_TIMEOUT(ACKT)) dut (
      .clk_in    (clk),
      .reset     (reset),
      .trig      (trig),
      .setpoint  (setpoint),
      .measure   (measure),
      .ctrl_out  (ctrl_out),
      .uart_busy (uart_busy),
      .send      (send),
      .send_data (send_data),
      .tlm_busy  (tlm_busy),
      .frame_done(frame_done),
      .err       (err),
      .drop_cnt  (drop_cnt)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];
   logic [7:0] last_exp;

   int busy_len = 10;
   bit no_ack = 1'b0;
   int ub_cnt = 0;
   bit prev_send = 1'b0;
   int nd = 0;
   int ne = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] s, input logic [15:0] m,
                             input logic [15:0] c);
      logic [7:0] sum;
      sum = s[15:8] + s[7:0] + m[15:8] + m[7:0] + c[15:8] + c[7:0];
      sb.push_back(8'hAA);
      sb.push_back(s[15:8]);
      sb.push_back(s[7:0]);
      sb.push_back(m[15:8]);
      sb.push_back(m[7:0]);
      sb.push_back(c[15:8]);
      sb.push_back(c[7:0]);
      last_exp = c[7:0];
`ifdef TLM_CHECKSUM_EN
      sb.push_back(sum);
      last_exp = sum;
`endif
   endtask

   task automatic do_trig();
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      chk("busy_after_trig", tlm_busy, 1);
   endtask

   task automatic wait_end(input bit scr, output bit found);
      found = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (scr) begin
            setpoint = 16'($urandom);
            measure  = 16'($urandom);
            ctrl_out = 16'($urandom);
         end
         if (frame_done || err) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // UART model and byte scoreboard
   always @(negedge clk) begin
      if (send) begin
         chk("no_back_to_back", prev_send, 0);
         if (sb.size() == 0) chk("unexpected_send", send_data, 32'hFFFF_FFFF);
         else chk("byte", send_data, sb.pop_front());
      end
      prev_send = send;
      if (send && !no_ack) begin
         ub_cnt = busy_len;
         uart_busy = 1'b1;
      end else if (ub_cnt > 0) begin
         ub_cnt--;
         if (ub_cnt == 0) uart_busy = 1'b0;
      end
      if (frame_done) nd++;
      if (err) ne++;
   end

   initial begin
      bit found;
      int k, t, ts, te, nd0, ne0;
      reset = 1'b1;
      trig = 1'b0;
      setpoint = '0;
      measure = '0;
      ctrl_out = '0;
      uart_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_send", send, 0);
      chk("rst_data", send_data, 0);
      chk("rst_busy", tlm_busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", err, 0);
      chk("rst_drop", drop_cnt, 0);
      reset = 1'b0;
      @(negedge clk);

      // reference frame, then a trigger on the frame_done cycle
      busy_len = 10;
      setpoint = 16'h1234;
      measure  = 16'h1200;
      ctrl_out = 16'h0034;
      push_frame(setpoint, measure, ctrl_out);
      do_trig();
      wait_end(1'b0, found);
      chk("a_found", found, 1);
      chk("a_done", frame_done, 1);
      chk("a_busy_fall", tlm_busy, 0);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      chk("a_drop_on_done", drop_cnt, 1);
      chk("a_no_restart", tlm_busy, 0);
      chk("a_sb_empty", sb.size(), 0);

      // drops during a long frame, then saturation
      busy_len = 60;
      setpoint = 16'hBEEF;
      measure  = 16'h0102;
      ctrl_out = 16'hFFFF;
      push_frame(setpoint, measure, ctrl_out);
      do_trig();
      repeat (3) begin
         trig = 1'b1;
         @(negedge clk);
      end
      trig = 1'b0;
      chk("b_drop3", drop_cnt, 4);
      trig = 1'b1;
      repeat (300) @(negedge clk);
      trig = 1'b0;
      chk("b_drop_sat", drop_cnt, 255);
      chk("b_still_busy", tlm_busy, 1);
      wait_end(1'b0, found);
      chk("b_found", found, 1);
      chk("b_done", frame_done, 1);
      @(negedge clk);
      chk("b_sb_empty", sb.size(), 0);
      chk("b_drop_hold", drop_cnt, 255);

      // ACK timeout
      busy_len = 10;
      no_ack = 1'b1;
      nd0 = nd;
      ne0 = ne;
      sb.push_back(8'hAA);
      do_trig();
      t = 0;
      ts = -1;
      te = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         t++;
         if (send && ts < 0) ts = t;
         if (err) begin
            te = t;
            break;
         end
      end
      chk("c_tmo_dist", te - ts, ACKT);
      chk("c_busy_fall", tlm_busy, 0);
      chk("c_no_done", frame_done, 0);
      no_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("c_sb_empty", sb.size(), 0);
      chk("c_err_cnt", ne - ne0, 1);
      chk("c_done_cnt", nd - nd0, 0);

      // reset after the third byte
      setpoint = 16'hCAFE;
      measure  = 16'h55AA;
      ctrl_out = 16'h0F0F;
      push_frame(setpoint, measure, ctrl_out);
      do_trig();
      k = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (send) k++;
         if (k == 3) break;
      end
      chk("d_three_sent", k, 3);
      nd0 = nd;
      ne0 = ne;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("d_send", send, 0);
      chk("d_data", send_data, 0);
      chk("d_busy", tlm_busy, 0);
      chk("d_done", frame_done, 0);
      chk("d_err", err, 0);
      chk("d_drop", drop_cnt, 0);
      chk("d_left", sb.size(), NB - 3);
      sb.delete();
      repeat (30) @(negedge clk);
      chk("d_no_done", nd - nd0, 0);
      chk("d_no_err", ne - ne0, 0);

      // fresh frame with inputs scrambled every cycle
      setpoint = 16'h1357;
      measure  = 16'h2468;
      ctrl_out = 16'h8001;
      push_frame(setpoint, measure, ctrl_out);
      do_trig();
      wait_end(1'b1, found);
      chk("e_found", found, 1);
      chk("e_done", frame_done, 1);
      @(negedge clk);
      chk("e_sb_empty", sb.size(), 0);
      chk("e_data_hold", send_data, last_exp);
      chk("e_done_total", nd, 3);
      chk("e_drop", drop_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
